// File: rtl/whitening_pkg.sv
// whitening_pkg: shared definitions for the whitening pipeline.
//   DATA_W, LOG2_N, N_SAMPLES : default sample width and frame size
//   cen_state_t               : centering unit FSM states
//   sat_data()                : clamp a DATA_W+1 bit signed value into DATA_W bits
package whitening_pkg;

    localparam int unsigned DATA_W    = 24;
    localparam int unsigned LOG2_N    = 7;
    localparam int unsigned N_SAMPLES = 1 << LOG2_N;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        DIV,
        SUB,
        DONE
    } cen_state_t;

    // The two top bits differ only when the value lies outside the DATA_W range.
    function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [DATA_W:0] v);
        if (v[DATA_W] != v[DATA_W-1]) begin
            sat_data = v[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            sat_data = v[DATA_W-1:0];
        end
    endfunction

endpackage

// File: rtl/cen_channel.sv
// cen_channel: per-channel datapath of the centering unit.
//   CLK_cen, RST_cen : clock, async active-high reset
//   clr              : clear accumulator and mean (start of a frame)
//   acc_en           : add x into the accumulator
//   mean_ld          : register accumulator / 2^LOG2_N (floor) as the mean
//   x                : signed input sample
//   mean             : registered mean
//   diff             : x - mean, saturated to DATA_W bits (combinational)
module cen_channel #(
    parameter int unsigned DATA_W = whitening_pkg::DATA_W,
    parameter int unsigned LOG2_N = whitening_pkg::LOG2_N
) (
    input  logic                     CLK_cen,
    input  logic                     RST_cen,
    input  logic                     clr,
    input  logic                     acc_en,
    input  logic                     mean_ld,
    input  logic signed [DATA_W-1:0] x,
    output logic signed [DATA_W-1:0] mean,
    output logic signed [DATA_W-1:0] diff
);
    import whitening_pkg::*;

    // Wide enough for 2^LOG2_N full-scale samples, so the sum never overflows.
    localparam int unsigned ACC_W = DATA_W + LOG2_N;

    logic signed [ACC_W-1:0]  acc_q;
    logic signed [DATA_W-1:0] mean_q;
    logic signed [DATA_W:0]   diff_wide;

    always_ff @(posedge CLK_cen or posedge RST_cen) begin
        if (RST_cen) begin
            acc_q  <= '0;
            mean_q <= '0;
        end else if (clr) begin
            acc_q  <= '0;
            mean_q <= '0;
        end else begin
            if (acc_en) begin
                acc_q <= acc_q + ACC_W'(x);
            end
            if (mean_ld) begin
                mean_q <= DATA_W'(acc_q >>> LOG2_N);
            end
        end
    end

    always_comb begin
        diff_wide = {x[DATA_W-1], x} - {mean_q[DATA_W-1], mean_q};
        diff      = sat_data(diff_wide);
    end

    assign mean = mean_q;

endmodule

// File: rtl/centering_unit.sv
// centering_unit: two-pass mean removal over one 2^LOG2_N sample frame.
//   CLK_cen, RST_cen : clock, async active-high reset
//   GO_cen           : level enable; low returns the unit to IDLE
//   in_valid/in_data : packed input samples, channel 0 in the LSBs
//   out_valid/out_data : registered centred samples (1-cycle latency in SUB)
//   mean_out         : per-channel means, valid from DIV until the next frame
//   CEN_busy         : high in ACCUM, DIV and SUB
//   cen_done         : pulse with the last centred output of a frame
module centering_unit #(
    parameter int unsigned N_CH   = 2,
    parameter int unsigned DATA_W = whitening_pkg::DATA_W,
    parameter int unsigned LOG2_N = whitening_pkg::LOG2_N
) (
    input  logic                     CLK_cen,
    input  logic                     RST_cen,
    input  logic                     GO_cen,
    input  logic                     in_valid,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    output logic                     out_valid,
    output logic [N_CH*DATA_W-1:0]   out_data,
    output logic [N_CH*DATA_W-1:0]   mean_out,
    output logic                     CEN_busy,
    output logic                     cen_done
);
    import whitening_pkg::*;

    cen_state_t state_q, state_d;
    logic [LOG2_N-1:0] cnt_q;

    logic take;
    logic last;
    logic clr;
    logic acc_en;
    logic sub_en;
    logic mean_ld;
    logic [N_CH*DATA_W-1:0] diff_all;

    // A sample is consumed only in a counting state while GO_cen holds.
    always_comb begin
        clr     = (state_q == IDLE) && GO_cen;
        take    = GO_cen && in_valid && ((state_q == ACCUM) || (state_q == SUB));
        last    = take && (cnt_q == '1);
        acc_en  = take && (state_q == ACCUM);
        sub_en  = take && (state_q == SUB);
        mean_ld = GO_cen && (state_q == DIV);
    end

    always_comb begin
        state_d = state_q;
        if (!GO_cen) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    state_d = ACCUM;
                ACCUM:   if (last) state_d = DIV;
                DIV:     state_d = SUB;
                SUB:     if (last) state_d = DONE;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_cen or posedge RST_cen) begin
        if (RST_cen) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            CEN_busy  <= 1'b0;
            cen_done  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (clr) begin
                cnt_q <= '0;
            end else if (take) begin
                cnt_q <= cnt_q + LOG2_N'(1);
            end
            out_valid <= sub_en;
            out_data  <= sub_en ? diff_all : '0;
            cen_done  <= sub_en && last;
            CEN_busy  <= (state_d == ACCUM) || (state_d == DIV) || (state_d == SUB);
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        cen_channel #(
            .DATA_W(DATA_W),
            .LOG2_N(LOG2_N)
        ) u_ch (
            .CLK_cen(CLK_cen),
            .RST_cen(RST_cen),
            .clr    (clr),
            .acc_en (acc_en),
            .mean_ld(mean_ld),
            .x      (in_data[c*DATA_W +: DATA_W]),
            .mean   (mean_out[c*DATA_W +: DATA_W]),
            .diff   (diff_all[c*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_centering_unit.sv
// tb_centering_unit: directed frames with hand-computed means and outputs.
module tb_centering_unit;

    localparam int K_C1000 = 0;
    localparam int K_RAMP  = 1;
    localparam int K_SAT   = 2;
    localparam int K_SEVEN = 3;
    localparam int K_FIVE  = 4;
    localparam int K_ABORT = 5;

    logic        CLK_cen = 1'b0;
    logic        RST_cen;
    logic        GO_cen;
    logic        in_valid;
    logic [47:0] in_data;
    logic        out_valid;
    logic [47:0] out_data;
    logic [47:0] mean_out;
    logic        CEN_busy;
    logic        cen_done;

    always #5 CLK_cen = ~CLK_cen;

    centering_unit #(
        .N_CH  (2),
        .DATA_W(24),
        .LOG2_N(7)
    ) dut (
        .CLK_cen  (CLK_cen),
        .RST_cen  (RST_cen),
        .GO_cen   (GO_cen),
        .in_valid (in_valid),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_data (out_data),
        .mean_out (mean_out),
        .CEN_busy (CEN_busy),
        .cen_done (cen_done)
    );

    int n_vec = 0;
    int n_err = 0;
    int busy_low;

    logic [47:0] q_out[$];
    int done_cnt    = 0;
    int done_orphan = 0;

    always @(negedge CLK_cen) begin
        if (out_valid) q_out.push_back(out_data);
        if (cen_done) begin
            done_cnt++;
            if (!out_valid) done_orphan++;
        end
    end

    task automatic chk(input string tag, input logic signed [47:0] obs,
                       input logic signed [47:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (%h), want %0d (%h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic [47:0] pk(input int a, input int b);
        pk = {b[23:0], a[23:0]};
    endfunction

    function automatic int chan(input logic [47:0] w, input int ch);
        logic signed [23:0] s;
        s = w[ch*24 +: 24];
        return int'(s);
    endfunction

    function automatic int sat24(input int v);
        if (v > 8388607) return 8388607;
        if (v < -8388608) return -8388608;
        return v;
    endfunction

    function automatic int smp(input int kind, input int pass, input int ch, input int i);
        case (kind)
            K_C1000: return 1000;
            K_RAMP:  return (ch == 0) ? i : -i;
            K_SAT:   return (ch == 0) ? ((pass == 0) ? -8388608 : 8388607) : 100;
            K_SEVEN: return 7;
            K_FIVE:  return 5;
            K_ABORT: return 99;
            default: return 0;
        endcase
    endfunction

    // Drives n samples starting at the next falling edge; busy is sampled on every drive edge.
    task automatic send_pass(input int kind, input int pass, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                for (int g = 0; g < 4 && $urandom_range(0, 1) == 1; g++) begin
                    @(negedge CLK_cen);
                    if (!CEN_busy) busy_low++;
                    in_valid = 1'b0;
                end
            end
            @(negedge CLK_cen);
            if (!CEN_busy) busy_low++;
            in_valid = 1'b1;
            in_data  = pk(smp(kind, pass, 0, i), smp(kind, pass, 1, i));
        end
    endtask

    task automatic run_frame(input string nm, input int kind, input bit gaps,
                             input int m0, input int m1);
        int ob;
        int db;
        ob = q_out.size();
        db = done_cnt;
        busy_low = 0;
        @(negedge CLK_cen);
        GO_cen   = 1'b1;
        in_valid = 1'b0;
        send_pass(kind, 0, 128, gaps);
        @(negedge CLK_cen);
        if (!CEN_busy) busy_low++;
        in_valid = 1'b0;
        send_pass(kind, 1, 128, gaps);
        @(negedge CLK_cen);
        in_valid = 1'b0;
        chk({nm, " done pulse"}, cen_done, 1);
        chk({nm, " last valid"}, out_valid, 1);
        chk({nm, " busy drop"}, CEN_busy, 0);
        chk({nm, " busy held"}, busy_low, 0);
        chk({nm, " mean"}, mean_out, pk(m0, m1));
        // Valid input in DONE must be ignored.
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK_cen);
            in_valid = 1'b1;
            in_data  = pk(i + 1, -i - 1);
        end
        @(negedge CLK_cen);
        in_valid = 1'b0;
        @(negedge CLK_cen);
        chk({nm, " out count"}, q_out.size() - ob, 128);
        chk({nm, " done count"}, done_cnt - db, 1);
        chk({nm, " done orphan"}, done_orphan, 0);
        for (int i = 0; i < 128; i++) begin
            if (ob + i < q_out.size()) begin
                chk($sformatf("%s out%0d", nm, i), q_out[ob + i],
                    pk(sat24(smp(kind, 1, 0, i) - m0), sat24(smp(kind, 1, 1, i) - m1)));
            end
        end
        GO_cen = 1'b0;
        @(negedge CLK_cen);
        @(negedge CLK_cen);
    endtask

    initial begin
        int ob;
        int db;
        RST_cen  = 1'b1;
        GO_cen   = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(negedge CLK_cen);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_data", out_data, 0);
        chk("rst mean_out", mean_out, 0);
        chk("rst busy", CEN_busy, 0);
        chk("rst done", cen_done, 0);
        RST_cen = 1'b0;
        @(negedge CLK_cen);
        chk("idle busy", CEN_busy, 0);

        run_frame("const1000", K_C1000, 1'b0, 1000, 1000);

        ob = q_out.size();
        run_frame("ramp", K_RAMP, 1'b0, 63, -64);
        chk("ramp ch0 first", chan(q_out[ob], 0), -63);
        chk("ramp ch1 first", chan(q_out[ob], 1), 64);
        chk("ramp ch0 last", chan(q_out[ob + 127], 0), 64);
        chk("ramp ch1 last", chan(q_out[ob + 127], 1), -63);

        ob = q_out.size();
        run_frame("sat", K_SAT, 1'b0, -8388608, 100);
        chk("sat ch0 clamp", chan(q_out[ob + 5], 0), 8388607);

        run_frame("gaps7", K_SEVEN, 1'b1, 7, 7);

        // Abort after 50 accumulated samples.
        @(negedge CLK_cen);
        GO_cen = 1'b1;
        send_pass(K_ABORT, 0, 50, 1'b0);
        @(negedge CLK_cen);
        GO_cen   = 1'b0;
        in_valid = 1'b0;
        db = done_cnt;
        @(negedge CLK_cen);
        chk("abort idle busy", CEN_busy, 0);
        repeat (3) @(negedge CLK_cen);
        chk("abort no done", done_cnt - db, 0);
        run_frame("after abort", K_FIVE, 1'b0, 5, 5);

        // Reset in the middle of the second pass.
        @(negedge CLK_cen);
        GO_cen = 1'b1;
        send_pass(K_RAMP, 0, 128, 1'b0);
        @(negedge CLK_cen);
        in_valid = 1'b0;
        send_pass(K_RAMP, 1, 60, 1'b0);
        @(negedge CLK_cen);
        chk("pre-rst valid", out_valid, 1);
        chk("pre-rst mean", mean_out, pk(63, -64));
        RST_cen = 1'b1;
        #1;
        chk("mid-rst out_valid", out_valid, 0);
        chk("mid-rst out_data", out_data, 0);
        chk("mid-rst mean_out", mean_out, 0);
        chk("mid-rst busy", CEN_busy, 0);
        chk("mid-rst done", cen_done, 0);
        @(negedge CLK_cen);
        in_valid = 1'b0;
        RST_cen  = 1'b0;
        run_frame("post-rst", K_C1000, 1'b0, 1000, 1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/centering_unit.md
# centering_unit

Mean-removal stage of the whitening pipeline, sitting between the raw-sample memory (mem1) and the covariance unit and mem2. It makes two passes over one 128-sample frame of multi-channel fixed-point data. The first pass accumulates a per-channel sum. The second pass re-reads the same samples and emits each sample minus the per-channel mean, which the covariance unit and mem2 consume. The whitening controller sequences it through `GO_cen` and observes `CEN_busy`.

## Interface
- `N_CH`, 2: number of mixed channels per sample word
- `DATA_W`, 24: signed two's-complement width of one channel sample
- `LOG2_N`, 7: log2 of samples per frame (frame = 128)

Ports:
- `CLK_cen`  in  1  clock; all state changes on its rising edge
- `RST_cen`  in  1  reset, asynchronous, active-high
- `GO_cen`  in  1  level enable from the whitening controller; low forces IDLE
- `in_valid`  in  1  `in_data` is valid this cycle
- `in_data`  in  N_CH*DATA_W  packed samples, channel 0 in LSBs
- `out_valid`  out  1  `out_data` is valid this cycle
- `out_data`  out  N_CH*DATA_W  packed centred samples, same packing as `in_data`
- `mean_out`  out  N_CH*DATA_W  per-channel means, held from DIV until next frame or reset
- `CEN_busy`  out  1  high in ACCUM, DIV and SUB
- `cen_done`  out  1  one-cycle pulse on the last centred output

## Operation
- States: IDLE, ACCUM, DIV, SUB, DONE.
- IDLE → ACCUM when `GO_cen` is high. On entry: accumulators, sample counter and `mean_out` all cleared.
- ACCUM:
  - Each `in_valid` cycle adds each channel into its own accumulator. Accumulator width is DATA_W+LOG2_N, signed, so it cannot overflow.
  - The counter increments per valid sample.
  - On the 128th valid sample (counter 127 → 0), go to DIV.
- DIV: exactly one cycle.
  - mean = accumulator >>> LOG2_N (arithmetic shift, i.e. floor), registered into `mean_out`.
  - `in_valid` is ignored in this cycle.
  - Next state is SUB.
- SUB:
  - Each `in_valid` sample produces, per channel, `x − mean` computed at DATA_W+1 bits and saturated to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
  - On the 128th valid sample, `cen_done` pulses and the state goes to DONE.
- DONE: outputs idle; stays in DONE until `GO_cen` goes low, then IDLE.
- `GO_cen` low in any state: IDLE on the next edge, partial sums discarded, no `cen_done`.
- `in_valid` in IDLE or DONE is ignored.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `mean_out`=0, `CEN_busy`=0, `cen_done`=0, state IDLE, counter 0, accumulators 0.
- `CEN_busy` is registered and goes high the cycle after `GO_cen` is first sampled high.
- SUB latency: input to output is 1 cycle. `out_valid`/`out_data` are registered from the `in_valid`/`in_data` of the previous cycle.
- `cen_done` is asserted in the same cycle as the 128th `out_valid`. `CEN_busy` drops in that same cycle.
- Gaps in `in_valid` are allowed in both passes. The counter advances only on valid samples.
- Minimum frame: 128 + 1 + 128 cycles, plus 1 cycle output latency.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous). The frame is lost.

## Structure
- Shared package `whitening_pkg` holds:
  - `DATA_W`, `LOG2_N` and `N_SAMPLES` defaults
  - the `cen_state_t` enum (IDLE, ACCUM, DIV, SUB, DONE)
  - a saturate-to-DATA_W function
- Sub-module `cen_channel`: one accumulator, mean register and saturating subtractor per channel. It is instantiated N_CH times under a generate loop.
- The top level holds the FSM, the 7-bit sample counter and the output registers.

## Test plan
- Constant 1000 on both channels for 128 samples, then again → `mean_out` = {1000, 1000}; 128 outputs of 0; `cen_done` on the last.
- Channel 0 ramp 0..127, channel 1 ramp 0..−127 → sums 8128 and −8128; means 63 and −64 (floor); channel 0 outputs −63..64, channel 1 outputs 64..−63.
- Pass 1 all −8388608 on channel 0, pass 2 all 8388607 → mean −8388608; outputs saturate to 8388607, no wrap.
- Random `in_valid` gaps (~50% duty) with a constant-7 frame → exactly 128 `out_valid` pulses of 0, one `cen_done`; `CEN_busy` high throughout.
- `GO_cen` dropped after 50 ACCUM samples, then re-raised with a full constant-5 frame → IDLE the next cycle, no `cen_done` for the aborted frame; new mean 5, not contaminated by the first 50 samples.
- `RST_cen` asserted during SUB at sample 60 → all outputs 0 the same cycle; after release with `GO_cen` high, a fresh ACCUM gives a correct result.
